// File: rtl/ex_issue_buffer_if.sv
// ID -> EX issue bus: the decoded op travelling from decode into the issue
// buffer, and the selected operands leaving it for the execute-stage FU.
// master = ID/EX environment side, slave = the issue buffer itself.
interface ex_issue_buffer_if #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) ();

   // ID side
   logic            in_valid;
   logic            in_ready;
   logic [6:0]      in_funct7;
   logic [2:0]      in_funct3;
   logic [XLEN-1:0] in_rs1_val;
   logic [XLEN-1:0] in_rs2_val;
   logic [XLEN-1:0] in_imm;
   logic            in_use_imm;
   logic [RD_W-1:0] in_rd;

   // EX side
   logic            out_valid;
   logic            out_ready;
   logic [6:0]      out_funct7;
   logic [2:0]      out_funct3;
   logic [XLEN-1:0] out_a;
   logic [XLEN-1:0] out_b;
   logic [RD_W-1:0] out_rd;

   modport master (
      output in_valid, in_funct7, in_funct3, in_rs1_val, in_rs2_val,
             in_imm, in_use_imm, in_rd, out_ready,
      input  in_ready, out_valid, out_funct7, out_funct3, out_a, out_b, out_rd
   );

   modport slave (
      input  in_valid, in_funct7, in_funct3, in_rs1_val, in_rs2_val,
             in_imm, in_use_imm, in_rd, out_ready,
      output in_ready, out_valid, out_funct7, out_funct3, out_a, out_b, out_rd
   );

endinterface

// File: rtl/ex_issue_buffer.sv
// ID/EX issue buffer: two-entry (MAIN + SKID) stage register in front of the
// execute-stage FU. Selects operand B, cleans funct7 for I-type ops and
// absorbs one cycle of EX backpressure without dropping or repeating ops.
module ex_issue_buffer #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   ex_issue_buffer_if.slave       bus
);

   // EMPTY: nothing held; ONE: MAIN valid; FULL: MAIN and SKID valid
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [6:0]      funct7;
      logic [2:0]      funct3;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [RD_W-1:0] rd;
   } op_t;

   state_t r_state;
   state_t w_state_next;

   op_t    r_main;
   op_t    r_skid;
   op_t    w_in_op;

   logic   w_in_ready;
   logic   w_out_valid;
   logic   w_push;
   logic   w_pop;
   logic   w_load_main_in;
   logic   w_load_main_skid;
   logic   w_load_skid;

   // Build the op as it will be stored: operand select and funct7 clean-up.
   // Only shift-immediates (SLLI/SRLI/SRAI) carry a real funct7 in imm[11:5];
   // every other I-type op forces funct7 to zero so the FU never sees SUB/SRA.
   always_comb begin
      w_in_op        = '0;
      w_in_op.funct3 = bus.in_funct3;
      w_in_op.a      = bus.in_rs1_val;
      w_in_op.b      = bus.in_use_imm ? bus.in_imm : bus.in_rs2_val;
      w_in_op.rd     = bus.in_rd;
      if (!bus.in_use_imm) begin
         w_in_op.funct7 = bus.in_funct7;
      end else if ((bus.in_funct3 == 3'b101) || (bus.in_funct3 == 3'b001)) begin
         w_in_op.funct7 = bus.in_imm[11:5];
      end else begin
         w_in_op.funct7 = 7'b0;
      end
   end

   assign w_push = bus.in_valid & w_in_ready;
   assign w_pop  = w_out_valid & bus.out_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and entry-load steering; flush overrides any push/pop
   always_comb begin
      w_state_next     = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush) begin
         w_state_next = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_push) begin
                  w_state_next   = ST_ONE;
                  w_load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_push && w_pop) begin
                  w_load_main_in = 1'b1;
               end else if (w_push) begin
                  w_state_next = ST_FULL;
                  w_load_skid  = 1'b1;
               end else if (w_pop) begin
                  w_state_next = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a pop can happen
               if (w_pop) begin
                  w_state_next     = ST_ONE;
                  w_load_main_skid = 1'b1;
               end
            end
            default: begin
               w_state_next = ST_EMPTY;
            end
         endcase
      end
   end

   // Handshake outputs: pure functions of state and rst, never of in_valid
   always_comb begin
      w_in_ready  = ~rst & (r_state != ST_FULL);
      w_out_valid = ~rst & ((r_state == ST_ONE) || (r_state == ST_FULL));
   end

   // Entry payload registers; SKID drains into MAIN to keep FIFO order
   always_ff @(posedge clk) begin
      if (rst) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main_in) begin
            r_main <= w_in_op;
         end else if (w_load_main_skid) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= w_in_op;
         end
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_funct7 = r_main.funct7;
   assign bus.out_funct3 = r_main.funct3;
   assign bus.out_a      = r_main.a;
   assign bus.out_b      = r_main.b;
   assign bus.out_rd     = r_main.rd;

endmodule
